// File: rtl/arb_req_pkg.sv
// Shared constants and types for the arbitration request stage.
// Optional feature macro: ARB_REQ_BYPASS_EN (same-cycle dequeue and refill of a slot).
package arb_req_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int DATA_W_DEF = 32;
  localparam int IDX_W_DEF  = $clog2(WIDTH_DEF);

  // Binary index of a requester port at the default width
  typedef logic [IDX_W_DEF-1:0] port_idx_t;

endpackage

// File: rtl/arb_oh_enc.sv
// Lowest-set-bit encoder: turns a (possibly multi-hot) vector into the binary
// index of its lowest set bit plus a flag saying any bit was set.
module arb_oh_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] oh_in,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      idx   = oh_in[i] ? IDX_W'(i) : idx;
      valid = valid | oh_in[i];
    end
  end

endmodule

// File: rtl/arb_req_stage.sv
// Per-port one-entry holding slots feeding an external round-robin arbiter;
// the granted slot is moved into a single registered output stage.
// Optional feature macro: ARB_REQ_BYPASS_EN -- a serviced port may be refilled
// in the same cycle it is dequeued (in_ready also depends on the grant).
module arb_req_stage
  import arb_req_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in_valid,
  output logic [WIDTH-1:0]           in_ready,
  input  logic [WIDTH*DATA_W-1:0]    in_data,
  output logic [WIDTH-1:0]           req,
  input  logic [WIDTH-1:0]           gnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(WIDTH)-1:0]   out_port,
  output logic                       err_multi
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0]              slot_valid_q, slot_valid_d;
  logic [WIDTH-1:0][DATA_W-1:0]  slot_data_q, slot_data_d;
  logic                          out_valid_q, out_valid_d;
  logic [DATA_W-1:0]             out_data_q, out_data_d;
  logic [IDX_W-1:0]              out_port_q, out_port_d;
  logic                          err_multi_q, err_multi_d;

  logic                          out_free_s;
  logic [WIDTH-1:0]              eg_s;
  logic                          multi_s;
  logic [IDX_W-1:0]              sel_idx_s;
  logic                          sel_valid_s;
  logic [WIDTH-1:0]              eg_sel_s;

  // Request only when the output register can take a payload; mask the grant by it
  always_comb begin
    out_free_s = ~out_valid_q | out_ready;
    req        = out_free_s ? slot_valid_q : '0;
    eg_s       = gnt & req;
    multi_s    = |(eg_s & (eg_s - WIDTH'(1)));
  end

  arb_oh_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .oh_in (eg_s),
    .idx   (sel_idx_s),
    .valid (sel_valid_s)
  );

  // One-hot of the serviced port and the per-port accept signal
  always_comb begin
    eg_sel_s = sel_valid_s ? (WIDTH'(1) << sel_idx_s) : '0;
`ifdef ARB_REQ_BYPASS_EN
    in_ready = ~slot_valid_q | eg_sel_s;
`else
    in_ready = ~slot_valid_q;
`endif
  end

  // Slot fill/drain, output register update and sticky multi-grant flag
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_port_d   = out_port_q;
    err_multi_d  = err_multi_q | multi_s;

    // A load wins over a dequeue: with bypass both can hit the same port
    for (int i = 0; i < WIDTH; i++) begin
      if (in_valid[i] & in_ready[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_data_d[i]  = in_data[i*DATA_W +: DATA_W];
      end else if (eg_sel_s[i]) begin
        slot_valid_d[i] = 1'b0;
      end else begin
        slot_valid_d[i] = slot_valid_q[i];
      end
    end

    if (sel_valid_s) begin
      out_valid_d = 1'b1;
      out_data_d  = slot_data_q[sel_idx_s];
      out_port_d  = sel_idx_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q <= '0;
      slot_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_port_q   <= '0;
      err_multi_q  <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_port_q   <= out_port_d;
      err_multi_q  <= err_multi_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_port  = out_port_q;
  assign err_multi = err_multi_q;

endmodule

// File: tb/tb_arb_req_stage.sv
// Scoreboard bench for arb_req_stage: a queue-based reference model predicts
// every transfer; a negedge monitor pops and compares on each output handshake.
module tb_arb_req_stage;
  import arb_req_pkg::*;

  localparam int W = 16;
  localparam int D = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [W-1:0]      in_valid = '0;
  logic [W-1:0]      in_ready;
  logic [W*D-1:0]    in_data = '0;
  logic [W-1:0]      req;
  logic [W-1:0]      gnt = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [D-1:0]      out_data;
  logic [3:0]        out_port;
  logic              err_multi;

  arb_req_stage dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_port  (out_port),
    .err_multi (err_multi)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    port_idx_t    port;
    logic [D-1:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [D-1:0] slot_m[W][$];
  logic         m_ov  = 1'b0;
  logic         m_err = 1'b0;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_hs     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the oldest predicted transfer
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      exp_t e;
      n_hs++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got port %0d data %0h expected nothing", out_port, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_port", 64'(out_port), 64'(e.port));
      end
    end
  end

  // Which ports the model says should request, given the downstream ready
  function automatic logic [W-1:0] model_req(input logic ordy);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++)
      if ((!m_ov || ordy) && slot_m[i].size() > 0) r[i] = 1'b1;
    return r;
  endfunction

  // One set bit of v, searching upward from a random start
  function automatic logic [W-1:0] pick_one(input logic [W-1:0] v, input int start);
    for (int k = 0; k < W; k++) begin
      int j = (start + k) % W;
      if (v[j]) return W'(1) << j;
    end
    return '0;
  endfunction

  // Entered just after a rising edge; drives one cycle and checks both sides of the edge
  task automatic cycle(input logic [W-1:0] iv, input logic [W*D-1:0] id,
                       input logic [W-1:0] g, input logic ordy);
    logic [W-1:0] er, eir;
    int sv, nm;
    in_valid = iv; in_data = id; gnt = g; out_ready = ordy;
    #1;
    er = model_req(ordy);
    sv = -1; nm = 0;
    for (int i = 0; i < W; i++)
      if (g[i] && er[i]) begin
        if (sv < 0) sv = i;
        nm++;
      end
    for (int i = 0; i < W; i++) eir[i] = (slot_m[i].size() == 0);
`ifdef ARB_REQ_BYPASS_EN
    if (sv >= 0) eir[sv] = 1'b1;
`endif
    chk("req", 64'(req), 64'(er));
    chk("in_ready", 64'(in_ready), 64'(eir));
    if (sv >= 0) begin
      exp_t e;
      e.port = port_idx_t'(sv);
      e.data = slot_m[sv].pop_front();
      sb.push_back(e);
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < W; i++)
      if (iv[i] && eir[i]) slot_m[i].push_back(id[i*D +: D]);
    if (nm > 1) m_err = 1'b1;
    @(posedge clock); #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("err_multi", 64'(err_multi), 64'(m_err));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = '1; gnt = W'($urandom); out_ready = 1'($urandom);
    #1;
    chk("rst_req", 64'(req), 64'(16'h0000));
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_in_ready", 64'(in_ready), 64'(16'hFFFF));
    chk("rst_err_multi", 64'(err_multi), 64'(1'b0));
    for (int i = 0; i < W; i++) slot_m[i].delete();
    sb.delete();
    m_ov = 1'b0; m_err = 1'b0;
    in_valid = '0; gnt = '0; out_ready = 1'b1;
    @(posedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  function automatic logic [W*D-1:0] rand_data();
    logic [W*D-1:0] d;
    for (int i = 0; i < W; i++) d[i*D +: D] = $urandom;
    return d;
  endfunction

  initial begin
    logic [W*D-1:0] dd;
    logic [D-1:0]   held;
    int             exp_rate;

    do_reset();

    // Single port 3
    dd = '0; dd[3*D +: D] = 32'hDEAD_BEEF;
    cycle(16'h0008, dd, 16'h0008, 1'b1);
    cycle(16'h0000, '0, 16'h0008, 1'b1);
    chk("single_data", 64'(out_data), 64'(32'hDEAD_BEEF));
    chk("single_port", 64'(out_port), 64'(4'd3));
    chk("single_ready3", 64'(in_ready[3]), 64'(1'b1));
    cycle(16'h0000, '0, 16'h0000, 1'b1);

    // Back-pressure with slots 0 and 5 held
    cycle(16'h0023, rand_data(), 16'h0000, 1'b1);
    cycle(16'h0000, '0, 16'h0002, 1'b0);
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      cycle(16'h0021, rand_data(), 16'h0021, 1'b0);
      chk("bp_data_stable", 64'(out_data), 64'(held));
      chk("bp_slots_kept", 64'({in_ready[5], in_ready[0]}), 64'(2'b00));
    end
    cycle(16'h0000, '0, 16'h0001, 1'b1);
    cycle(16'h0000, '0, 16'h0020, 1'b1);
    cycle(16'h0000, '0, 16'h0000, 1'b1);

    // Multi-hot grant on slots 2 and 7
    cycle(16'h0084, rand_data(), 16'h0000, 1'b1);
    cycle(16'h0000, '0, 16'h0084, 1'b1);
    chk("multi_port", 64'(out_port), 64'(4'd2));
    chk("multi_err", 64'(err_multi), 64'(1'b1));
    chk("multi_keep7", 64'(in_ready[7]), 64'(1'b0));
    cycle(16'h0000, '0, 16'h0080, 1'b1);
    cycle(16'h0000, '0, 16'h0000, 1'b1);
    do_reset();

    // Spurious grant: only slot 1 full, grant on port 4
    cycle(16'h0002, rand_data(), 16'h0000, 1'b1);
    cycle(16'h0000, '0, 16'h0010, 1'b1);
    chk("spur_out_valid", 64'(out_valid), 64'(1'b0));
    chk("spur_err", 64'(err_multi), 64'(1'b0));
    cycle(16'h0000, '0, 16'h0002, 1'b1);
    cycle(16'h0000, '0, 16'h0000, 1'b1);

    // Streaming on port 0
    do_reset();
    n_hs = 0;
    for (int k = 0; k < 22; k++) cycle(16'h0001, rand_data(), 16'h0001, 1'b1);
`ifdef ARB_REQ_BYPASS_EN
    exp_rate = 20;
`else
    exp_rate = 10;
`endif
    chk("stream_rate", 64'(n_hs), 64'(exp_rate));
    for (int k = 0; k < 3; k++) cycle(16'h0000, '0, 16'h0001, 1'b1);

    // Randomized traffic, with a reset in the middle
    for (int k = 0; k < 600; k++) begin
      logic          ordy;
      logic [W-1:0]  g, iv;
      int            mode;
      if (k == 300) do_reset();
      ordy = ($urandom_range(3) != 0);
      mode = $urandom_range(7);
      case (mode)
        0, 1, 2, 3: g = pick_one(model_req(ordy), $urandom_range(W-1));
        4:          g = W'(1) << $urandom_range(W-1);
        5:          g = ($urandom_range(7) == 0) ? W'($urandom) : '0;
        default:    g = '0;
      endcase
      iv = W'($urandom) & W'($urandom);
      cycle(iv, rand_data(), g, ordy);
    end

    // Drain everything still held
    for (int k = 0; k < 40; k++)
      cycle(16'h0000, '0, pick_one(model_req(1'b1), 0), 1'b1);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    chk("all_slots_free", 64'(in_ready), 64'(16'hFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_req_stage.md
ARB_REQ_STAGE -- requirements
Module: arb_req_stage

Interface
REQ-001 Parameter: WIDTH, default 16, number of requester ports.
REQ-002 Parameter: DATA_W, default 32, payload width per port.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port: clock  input  1  rising-edge clock.
REQ-005 Port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: in_valid  input  WIDTH  per-port payload offered.
REQ-007 Port: in_ready  output  WIDTH  per-port holding slot can accept.
REQ-008 Port: in_data  input  WIDTH*DATA_W  port i payload in bits [i*DATA_W +: DATA_W].
REQ-009 Port: req  output  WIDTH  request vector to the external round-robin arbiter.
REQ-010 Port: gnt  input  WIDTH  one-hot grant from the arbiter, same-cycle combinational response to req.
REQ-011 Port: out_valid  output  1  granted payload available.
REQ-012 Port: out_ready  input  1  downstream accepts out_data.
REQ-013 Port: out_data  output  DATA_W  granted payload.
REQ-014 Port: out_port  output  $clog2(WIDTH)  index of the port that supplied out_data.
REQ-015 Port: err_multi  output  1  sticky flag, grant with more than one bit set.

Function
REQ-016 Each port has a one-entry holding slot (slot_valid[i], slot_data[i]); in_valid[i] & in_ready[i] at a rising edge loads the slot.
REQ-017 in_ready[i] = ~slot_valid[i] (bypass per REQ-031).
REQ-018 out_free = ~out_valid | out_ready; req = slot_valid when out_free, else all zeros.
REQ-019 Effective grant eg = gnt & req; bits of gnt without a matching req are ignored.
REQ-020 If eg has more than one bit set, the lowest set index is serviced and err_multi sets and stays set until reset.
REQ-021 When eg is nonzero, at the next edge: slot_valid of serviced port clears, out_valid=1, out_data=its slot_data, out_port=its index.
REQ-022 When eg is zero and out_ready=1, out_valid clears at next edge; out_data/out_port hold.
REQ-023 Output register holds stable while out_valid & ~out_ready.
REQ-024 Latency: in handshake at edge t -> req visible after t; grant in that cycle -> out_valid after edge t+1 (two edges in to out).
REQ-025 Throughput: one payload per cycle sustained when out_ready=1 and gnt nonzero every cycle.
REQ-026 Payload order per port preserved; no payload dropped or duplicated.
REQ-027 Downstream back-pressure (out_valid & ~out_ready) forces req=0, so no slot is consumed.

Reset
REQ-028 reset_n low asynchronously clears slot_valid, out_valid, err_multi, out_data, out_port, slot_data to zero.
REQ-029 Outputs during reset: req=0, out_valid=0, in_ready=all ones, err_multi=0.
REQ-030 Reset mid-transfer discards held and output payloads; operation resumes on the first edge after reset_n deasserts.

Configuration
REQ-031 Macro ARB_REQ_BYPASS_EN defined: in_ready[i] = ~slot_valid[i] | eg_sel[i], where eg_sel is the one-hot of the serviced port, allowing same-cycle dequeue and refill; undefined: REQ-017 holds exactly and a serviced port is refillable one cycle later.

Structure
REQ-032 Package arb_req_pkg holds default WIDTH/DATA_W constants and the port-index typedef.
REQ-033 Sub-module arb_oh_enc converts the lowest set bit of eg to a binary index plus a valid bit; it is instantiated once.

Verification
REQ-034 Reset: reset_n=0 with in_valid=all ones -> req=0, out_valid=0, in_ready=16'hFFFF.
REQ-035 Single port: in_data[3]=32'hDEAD_BEEF, gnt=16'h0008 -> out_valid after two edges, out_data=32'hDEAD_BEEF, out_port=3, in_ready[3] high again.
REQ-036 Back-pressure: out_valid=1, out_ready=0 for 5 cycles with slots 0 and 5 full -> req=0, out_data stable, both slots retained.
REQ-037 Multi-hot: slots 2 and 7 full, gnt=16'h0084 -> port 2 serviced, slot 7 kept, err_multi=1 until reset.
REQ-038 Spurious grant: only slot 1 full, gnt=16'h0010 -> no transfer, out_valid unchanged, err_multi=0.
REQ-039 Streaming with ARB_REQ_BYPASS_EN: port 0 valid every cycle, gnt=16'h0001, out_ready=1 -> one out per cycle; without the macro -> one out every two cycles.
